// File: rtl/convex_pt_feeder_pkg.sv
// ---------------------------------------------------------------------------
// convex_pt_feeder_pkg
// Shared types and constants for the CONVEX point feeder.
//   COORD_W   : coordinate width (two PT_XY nibbles per coordinate)
//   NIB_W     : PT_XY nibble width
//   point_t   : one buffered host point {x, y}
//   feed_st_e : serializer state (IDLE, then one state per nibble)
// ---------------------------------------------------------------------------
package convex_pt_feeder_pkg;

  localparam int COORD_W = 10;
  localparam int NIB_W   = 5;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    N0   = 3'd1,
    N1   = 3'd2,
    N2   = 3'd3,
    N3   = 3'd4
  } feed_st_e;

endpackage

// File: rtl/convex_pt_feeder_if.sv
// ---------------------------------------------------------------------------
// convex_pt_feeder_if
// Bundles the host point handshake and the CONVEX point bus.
//   IN_X, IN_Y, IN_VALID, IN_READY : host -> feeder point handshake
//   READ_PT                        : CONVEX request for the next point
//   PT_XY, PT_SOF                  : serialized point nibbles to CONVEX
//
// Handshake: a point transfers at the rising edge where IN_VALID and
// IN_READY are both high. IN_VALID may be raised at any time and must hold
// the point stable until that edge; IN_READY does not depend on IN_VALID.
// READ_PT is a level request that CONVEX holds until it sees PT_SOF.
//
// Modports: slave = the feeder, master = the host/CONVEX side.
// ---------------------------------------------------------------------------
interface convex_pt_feeder_if;
  import convex_pt_feeder_pkg::*;

  logic [COORD_W-1:0] IN_X;
  logic [COORD_W-1:0] IN_Y;
  logic               IN_VALID;
  logic               IN_READY;
  logic               READ_PT;
  logic [NIB_W-1:0]   PT_XY;
  logic               PT_SOF;

  modport slave (
    input  IN_X, IN_Y, IN_VALID, READ_PT,
    output IN_READY, PT_XY, PT_SOF
  );

  modport master (
    output IN_X, IN_Y, IN_VALID, READ_PT,
    input  IN_READY, PT_XY, PT_SOF
  );

endinterface

// File: rtl/convex_pt_feeder_pt_fifo.sv
// ---------------------------------------------------------------------------
// convex_pt_feeder_pt_fifo
// Synchronous FIFO of point_t, no fall-through (a pushed entry is visible at
// dout only after the push edge).
//   CLK, RST_N : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty) and current head
//   full, empty, count : occupancy status, count in 0..DEPTH
// ---------------------------------------------------------------------------
module convex_pt_feeder_pt_fifo
  import convex_pt_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  point_t                   din,
  input  logic                     pop,
  output point_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  point_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the pre-edge count, so a pop in the same cycle does
  // not open a slot for a push.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/convex_pt_feeder.sv
// ---------------------------------------------------------------------------
// convex_pt_feeder
// Buffers host points and serializes each one to CONVEX on request as four
// nibbles: X[9:5], X[4:0], Y[9:5], Y[4:0].
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : host handshake + CONVEX point bus (slave modport)
//   BUSY       : serializer transmitting a point (N0..N3)
//   FIFO_CNT   : points currently buffered
//   PT_CNT     : points fully sent, wraps at 256
//   DBG_STATE  : serializer state register
// ---------------------------------------------------------------------------
module convex_pt_feeder
  import convex_pt_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  convex_pt_feeder_if.slave        bus,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   FIFO_CNT,
  output logic [7:0]               PT_CNT,
  output feed_st_e                 DBG_STATE
);

  feed_st_e state;
  point_t   shadow;
  point_t   head;
  point_t   in_pt;
  logic     full;
  logic     empty;
  logic     pop;

  assign in_pt = '{x: bus.IN_X, y: bus.IN_Y};

  convex_pt_feeder_pt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (bus.IN_VALID),
    .din   (in_pt),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (FIFO_CNT)
  );

  assign bus.IN_READY = !full;

  // A new point is taken only from IDLE or from the last nibble state, the
  // latter giving gapless back-to-back points while READ_PT stays high.
  assign pop = ((state == IDLE) || (state == N3)) && bus.READ_PT && !empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      shadow <= '0;
      PT_CNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shadow <= head;
            state  <= N0;
          end
        end
        N0: state <= N1;
        N1: state <= N2;
        N2: state <= N3;
        N3: begin
          PT_CNT <= PT_CNT + 8'd1;
          if (pop) begin
            shadow <= head;
            state  <= N0;
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.PT_XY = '0;
    case (state)
      N0:      bus.PT_XY = shadow.x[COORD_W-1 -: NIB_W];
      N1:      bus.PT_XY = shadow.x[NIB_W-1:0];
      N2:      bus.PT_XY = shadow.y[COORD_W-1 -: NIB_W];
      N3:      bus.PT_XY = shadow.y[NIB_W-1:0];
      default: bus.PT_XY = '0;
    endcase
  end

  assign bus.PT_SOF = (state == N0);
  assign BUSY       = (state != IDLE);
  assign DBG_STATE  = state;

endmodule

// File: tb/tb_convex_pt_feeder.sv
// ---------------------------------------------------------------------------
// tb_convex_pt_feeder
// Self-checking bench for convex_pt_feeder. The reference model is a queue of
// pushed points plus a buffered-point count and a sent-point count; expected
// nibbles are sliced arithmetically from the queued point.
// ---------------------------------------------------------------------------
module tb_convex_pt_feeder;
  import convex_pt_feeder_pkg::*;

  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST_N;
  logic       busy;
  logic [3:0] fifo_cnt;
  logic [7:0] pt_cnt;
  feed_st_e   dbg_state;

  always #5 CLK = ~CLK;

  convex_pt_feeder_if bus ();

  convex_pt_feeder #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .BUSY      (busy),
    .FIFO_CNT  (fifo_cnt),
    .PT_CNT    (pt_cnt),
    .DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [19:0] exp_q[$];
  int          fifo_n;
  logic [7:0]  model_pt_cnt;
  int          n_checks;
  int          n_fail;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Presents one point for one cycle; called just after a falling edge.
  task automatic push_pt(input logic [9:0] x, input logic [9:0] y);
    logic exp_rdy;
    exp_rdy      = (fifo_n < DEPTH);
    bus.IN_X     = x;
    bus.IN_Y     = y;
    bus.IN_VALID = 1'b1;
    n_checks++;
    if (bus.IN_READY !== exp_rdy) begin
      $display("FAIL in_ready fifo_n=%0d: got %b, required %b", fifo_n, bus.IN_READY, exp_rdy);
      n_fail++;
    end
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    if (exp_rdy) begin
      exp_q.push_back({x, y});
      fifo_n++;
    end
  endtask

  // Requests n points and checks them against the model queue. The first
  // point may take up to max_wait cycles to start; later ones must follow
  // with no gap.
  task automatic read_points(input int n, input int max_wait);
    int          w;
    logic [19:0] pt;
    logic [4:0]  exp_nib;
    bus.READ_PT = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!bus.PT_SOF && w < ((i == 0) ? max_wait : 0)) begin
        @(negedge CLK);
        w++;
      end
      n_checks++;
      if (bus.PT_SOF !== 1'b1) begin
        $display("FAIL sof_start point %0d: PT_SOF=%b after %0d cycles, required 1", i, bus.PT_SOF, w);
        n_fail++;
        bus.READ_PT = 1'b0;
        return;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL model_empty point %0d: DUT sent a point, model holds 0", i);
        n_fail++;
        bus.READ_PT = 1'b0;
        return;
      end
      pt = exp_q.pop_front();
      fifo_n--;
      n_checks++;
      if (fifo_cnt !== 4'(fifo_n)) begin
        $display("FAIL fifo_cnt_pop point %0d: got %0d, required %0d", i, fifo_cnt, fifo_n);
        n_fail++;
      end
      n_checks++;
      if (bus.IN_READY !== (fifo_n < DEPTH)) begin
        $display("FAIL in_ready_pop point %0d: got %b, required %b", i, bus.IN_READY, (fifo_n < DEPTH));
        n_fail++;
      end
      for (int j = 0; j < 4; j++) begin
        exp_nib = 5'((pt >> (15 - 5 * j)) & 20'h1f);
        n_checks++;
        if (bus.PT_XY !== exp_nib || bus.PT_SOF !== (j == 0) || busy !== 1'b1) begin
          $display("FAIL nibble point %0d idx %0d: PT_XY=%0d SOF=%b BUSY=%b, required PT_XY=%0d SOF=%b BUSY=1",
                   i, j, bus.PT_XY, bus.PT_SOF, busy, exp_nib, (j == 0));
          n_fail++;
        end
        if (j == 0 && i == n - 1) bus.READ_PT = 1'b0;
        @(negedge CLK);
      end
      model_pt_cnt = model_pt_cnt + 8'd1;
    end
    n_checks++;
    if (busy !== 1'b0 || bus.PT_XY !== 5'd0 || pt_cnt !== model_pt_cnt) begin
      $display("FAIL after_read: BUSY=%b PT_XY=%0d PT_CNT=%0d, required BUSY=0 PT_XY=0 PT_CNT=%0d",
               busy, bus.PT_XY, pt_cnt, model_pt_cnt);
      n_fail++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST_N        = 1'b0;
    bus.IN_X     = '0;
    bus.IN_Y     = '0;
    bus.IN_VALID = 1'b0;
    bus.READ_PT  = 1'b0;
    exp_q.delete();
    fifo_n       = 0;
    model_pt_cnt = 8'd0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (bus.IN_READY !== 1'b1 || busy !== 1'b0 || bus.PT_XY !== 5'd0 || bus.PT_SOF !== 1'b0 ||
        fifo_cnt !== 4'd0 || pt_cnt !== 8'd0 || dbg_state !== IDLE) begin
      $display("FAIL reset_state: RDY=%b BUSY=%b PT_XY=%0d SOF=%b CNT=%0d PT_CNT=%0d ST=%0d, required 1 0 0 0 0 0 0",
               bus.IN_READY, busy, bus.PT_XY, bus.PT_SOF, fifo_cnt, pt_cnt, dbg_state);
      n_fail++;
    end
  endtask

  task automatic test_single();
    bus.READ_PT = 1'b1;
    push_pt(10'd517, 10'd300);
    n_checks++;
    if (bus.PT_SOF !== 1'b0 || fifo_cnt !== 4'd1) begin
      $display("FAIL single_no_fallthrough: SOF=%b CNT=%0d, required SOF=0 CNT=1", bus.PT_SOF, fifo_cnt);
      n_fail++;
    end
    read_points(1, 1);
    n_checks++;
    if (pt_cnt !== 8'd1) begin
      $display("FAIL single_pt_cnt: got %0d, required 1", pt_cnt);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    n_checks++;
    if (fifo_cnt !== 4'd3) begin
      $display("FAIL b2b_fill: got %0d, required 3", fifo_cnt);
      n_fail++;
    end
    read_points(3, 2);
    n_checks++;
    if (fifo_cnt !== 4'd0) begin
      $display("FAIL b2b_drain: got %0d, required 0", fifo_cnt);
      n_fail++;
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    n_checks++;
    if (fifo_cnt !== 4'd8 || bus.IN_READY !== 1'b0) begin
      $display("FAIL full_state: CNT=%0d RDY=%b, required CNT=8 RDY=0", fifo_cnt, bus.IN_READY);
      n_fail++;
    end
    // Ninth point offered in the same cycle as a pop: must be refused.
    bus.READ_PT = 1'b1;
    push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    read_points(1, 0);
    n_checks++;
    if (bus.IN_READY !== 1'b1 || fifo_cnt !== 4'd7) begin
      $display("FAIL full_after_read: RDY=%b CNT=%0d, required RDY=1 CNT=7", bus.IN_READY, fifo_cnt);
      n_fail++;
    end
    read_points(7, 2);
  endtask

  task automatic test_wait_empty();
    bus.READ_PT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.PT_XY !== 5'd0 || busy !== 1'b0 || bus.PT_SOF !== 1'b0) begin
        $display("FAIL wait_empty cycle %0d: PT_XY=%0d BUSY=%b SOF=%b, required 0 0 0", i, bus.PT_XY, busy, bus.PT_SOF);
        n_fail++;
      end
    end
    push_pt(10'd1023, 10'd0);
    n_checks++;
    if (bus.PT_SOF !== 1'b0) begin
      $display("FAIL wait_latency: SOF=%b one edge after push, required 0", bus.PT_SOF);
      n_fail++;
    end
    read_points(1, 1);
  endtask

  task automatic test_reset_mid();
    int w;
    push_pt(10'd1, 10'd2);
    push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    bus.READ_PT = 1'b1;
    w = 0;
    while (!bus.PT_SOF && w < 3) begin
      @(negedge CLK);
      w++;
    end
    bus.READ_PT = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus.PT_XY !== 5'd1) begin
      $display("FAIL mid_n1: PT_XY=%0d, required 1", bus.PT_XY);
      n_fail++;
    end
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b1 || bus.PT_XY !== 5'd0) begin
      $display("FAIL mid_n2: BUSY=%b PT_XY=%0d, required BUSY=1 PT_XY=0", busy, bus.PT_XY);
      n_fail++;
    end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.PT_XY !== 5'd0 || bus.PT_SOF !== 1'b0) begin
      $display("FAIL async_reset: BUSY=%b PT_XY=%0d SOF=%b, required 0 0 0", busy, bus.PT_XY, bus.PT_SOF);
      n_fail++;
    end
    @(negedge CLK);
    RST_N = 1'b1;
    exp_q.delete();
    fifo_n       = 0;
    model_pt_cnt = 8'd0;
    @(negedge CLK);
    n_checks++;
    if (fifo_cnt !== 4'd0 || pt_cnt !== 8'd0 || bus.IN_READY !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release: CNT=%0d PT_CNT=%0d RDY=%b BUSY=%b, required 0 0 1 0",
               fifo_cnt, pt_cnt, bus.IN_READY, busy);
      n_fail++;
    end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 4; i++) push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    n_checks++;
    if (fifo_cnt !== 4'd4) begin
      $display("FAIL conc_fill: got %0d, required 4", fifo_cnt);
      n_fail++;
    end
    bus.READ_PT = 1'b1;
    push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    // read_points checks FIFO_CNT stays 4 at the first start-of-point.
    read_points(5, 0);
  endtask

  task automatic test_random();
    int k;
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, DEPTH);
      for (int i = 0; i < k; i++) push_pt(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      read_points(k, 2);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wait_empty();
    test_random();
    test_reset_mid();
    test_concurrent();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
